// File: rtl/axis_pool_pkg.sv
// Shared types and helpers for the 2x2 max-pool / ReLU stream stage.
// State encoding is {row parity, column parity} of the beat about to be accepted.
package axis_pool_pkg;

    typedef enum logic [1:0] {
        E0 = 2'b00,
        E1 = 2'b01,
        O0 = 2'b10,
        O1 = 2'b11
    } pool_state_t;

    localparam int unsigned MAX_W = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [MAX_W-1:0] max2(input logic signed [MAX_W-1:0] a,
                                                     input logic signed [MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row buffer of even-row pair maxima; synchronous write, synchronous read
// whose output register only changes on a read enable.
module pool_line_buffer
    import axis_pool_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_relu_maxpool.sv
// AXI4-Stream 2x2/stride-2 signed max pooling followed by ReLU over IMG_W x IMG_H frames.
// The output register is the only output storage; input stalls while it is full and not ready.
module axis_relu_maxpool
    import axis_pool_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned IMG_W              = 16,
    parameter int unsigned IMG_H              = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic                              s00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tlast,
    output logic                              frame_err
);

    localparam int unsigned W  = C_AXIS_TDATA_WIDTH;
    localparam int unsigned CW = idx_width(IMG_W);
    localparam int unsigned RW = idx_width(IMG_H);
    localparam int unsigned AW = idx_width(IMG_W / 2);

    logic                    aresetn_q;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    pool_state_t             state;
    logic [W-1:0]            pair;
    logic [W-1:0]            lb_rdata;
    logic [W-1:0]            lb_wdata;
    logic [AW-1:0]           lb_addr;
    logic                    accept;
    logic                    col_end;
    logic                    frame_end;
    logic signed [MAX_W-1:0] v;
    logic [W-1:0]            relu_v;
    logic                    unused_tstrb;

    assign unused_tstrb    = ^s00_axis_tstrb;
    assign m00_axis_tstrb  = '1;
    assign s00_axis_tready = aresetn_q & (~m00_axis_tvalid | m00_axis_tready);
    assign accept          = s00_axis_tvalid & s00_axis_tready;
    assign col_end         = (col == CW'(IMG_W - 1));
    assign frame_end       = col_end && (row == RW'(IMG_H - 1));
    assign lb_addr         = AW'(col >> 1);

    always_comb begin
        lb_wdata = W'(max2(MAX_W'($signed(pair)), MAX_W'($signed(s00_axis_tdata))));
        v        = max2(MAX_W'($signed(lb_rdata)),
                        max2(MAX_W'($signed(pair)), MAX_W'($signed(s00_axis_tdata))));
        relu_v   = v[MAX_W-1] ? '0 : W'(v);
    end

    always_ff @(posedge s00_axis_aclk) begin
        aresetn_q <= s00_axis_aresetn;
    end

    // Any tlast/position disagreement flags the frame and re-aligns to the top-left corner.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            col       <= '0;
            row       <= '0;
            state     <= E0;
            pair      <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (state == E0 || state == O0) pair <= s00_axis_tdata;
            if (s00_axis_tlast != frame_end) frame_err <= 1'b1;
            if (frame_end || s00_axis_tlast) begin
                col   <= '0;
                row   <= '0;
                state <= E0;
            end else begin
                if (col_end) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                unique case (state)
                    E0: state <= E1;
                    E1: state <= col_end ? O0 : E0;
                    O0: state <= O1;
                    O1: state <= col_end ? E0 : O0;
                endcase
            end
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (accept && state == O1) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= frame_end;
            m00_axis_tdata  <= relu_v;
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
        end
    end

    pool_line_buffer #(
        .DEPTH (IMG_W / 2),
        .WIDTH (W),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (s00_axis_aclk),
        .wr_en   (accept && state == E1),
        .wr_addr (lb_addr),
        .wr_data (lb_wdata),
        .rd_en   (accept && state == O0),
        .rd_addr (lb_addr),
        .rd_data (lb_rdata)
    );

endmodule
